// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator request scheduler.
//   state_t    : car sequencer states (IDLE, MOVE_UP, MOVE_DN, DOOR)
//   DIR_*      : encodings driven on the dir output
//   DEFAULT_NUM_FLOORS / FLOOR_W : floor count and fixed floor index width
package elevator_pkg;

    localparam int DEFAULT_NUM_FLOORS = 5;
    localparam int FLOOR_W            = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MOVE_UP = 3'd1,
        MOVE_DN = 3'd2,
        DOOR    = 3'd3
    } state_t;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DN   = 2'b10;

endpackage

// File: rtl/elevator_dir_select.sv
// Combinational SCAN direction decision.
// Ports:
//   pending   in  latched unserved floor requests
//   floor     in  current car floor
//   last_dir  in  direction of the last sweep (0 up, 1 down)
//   sweep     in  1: requests on both sides follow last_dir (door exit)
//                 0: requests on both sides go to the nearest side, ties up (idle)
//   go_up     out move up next
//   go_down   out move down next
//   stop_here out the current floor itself is requested
module elevator_dir_select
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = DEFAULT_NUM_FLOORS
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    floor,
    input  logic                  last_dir,
    input  logic                  sweep,
    output logic                  go_up,
    output logic                  go_down,
    output logic                  stop_here
);

    logic [NUM_FLOORS-1:0] above;
    logic [NUM_FLOORS-1:0] below;
    logic                  has_above;
    logic                  has_below;
    int                    up_dist;
    int                    dn_dist;

    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_side
        assign above[gi] = pending[gi] & (gi > int'(floor));
        assign below[gi] = pending[gi] & (gi < int'(floor));
    end

    assign has_above = |above;
    assign has_below = |below;

    always_comb begin
        up_dist = NUM_FLOORS;
        dn_dist = NUM_FLOORS;
        // Scan downward so the closest request above wins.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (above[i]) up_dist = i - int'(floor);
        end
        // Scan upward so the closest request below wins.
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (below[i]) dn_dist = int'(floor) - i;
        end
    end

    always_comb begin
        stop_here = pending[floor];
        go_up     = 1'b0;
        go_down   = 1'b0;
        if (!stop_here) begin
            if (has_above && has_below) begin
                if (sweep) begin
                    go_up   = ~last_dir;
                    go_down = last_dir;
                end else begin
                    go_up   = (up_dist <= dn_dist);
                    go_down = (up_dist > dn_dist);
                end
            end else begin
                go_up   = has_above;
                go_down = has_below;
            end
        end
    end

endmodule

// File: rtl/elevator_request_scheduler.sv
// Request-latching SCAN scheduler and car sequencer.
// Latches call buttons into a pending mask, sequences the car floor by floor
// with a travel timer, holds the door open for a fixed interval at each stop
// and picks the next direction in collective (SCAN) order.
// Ports:
//   clk        in  clock, rising edge
//   rst        in  asynchronous active-low reset
//   req        in  call buttons, bit i = floor i
//   floor      out current car floor
//   dir        out 00 idle/stopped, 01 up, 10 down
//   state      out 0 IDLE, 1 MOVE_UP, 2 MOVE_DN, 3 DOOR
//   door_open  out high while in DOOR
//   pending    out latched unserved requests
//   busy       out car active or requests outstanding
// Build option: define ELEV_DOOR_REOPEN_EN so that a call for the current floor
// during DOOR restarts the door timer; otherwise the call is absorbed.
module elevator_request_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = DEFAULT_NUM_FLOORS,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] req,
    output logic [FLOOR_W-1:0]    floor,
    output logic [1:0]            dir,
    output logic [2:0]            state,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  busy
);

    // One counter serves both the travel and the door timer; the two
    // intervals never overlap.
    localparam int MAX_CYCLES = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0]   TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0]   DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

    state_t                state_reg, state_next;
    logic [FLOOR_W-1:0]    floor_reg, floor_next, arrive_floor;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic                  last_dir_reg, last_dir_next;
    logic [NUM_FLOORS-1:0] pending_reg, clear_mask;
    logic                  go_up, go_down, stop_here;

    elevator_dir_select #(
        .NUM_FLOORS (NUM_FLOORS)
    ) u_dir_select (
        .pending   (pending_reg),
        .floor     (floor_reg),
        .last_dir  (last_dir_reg),
        .sweep     (state_reg == DOOR),
        .go_up     (go_up),
        .go_down   (go_down),
        .stop_here (stop_here)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            floor_reg    <= '0;
            cnt_reg      <= '0;
            last_dir_reg <= 1'b0;
            pending_reg  <= '0;
        end else begin
            floor_reg    <= floor_next;
            cnt_reg      <= cnt_next;
            last_dir_reg <= last_dir_next;
            pending_reg  <= (pending_reg | req) & ~clear_mask;
        end
    end

    // Next-state logic
    always_comb begin
        state_next    = state_reg;
        floor_next    = floor_reg;
        cnt_next      = cnt_reg;
        last_dir_next = last_dir_reg;
        clear_mask    = '0;
        arrive_floor  = floor_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (stop_here) begin
                    state_next            = DOOR;
                    clear_mask[floor_reg] = 1'b1;
                end else if (go_up) begin
                    state_next    = MOVE_UP;
                    last_dir_next = 1'b0;
                end else if (go_down) begin
                    state_next    = MOVE_DN;
                    last_dir_next = 1'b1;
                end
            end
            MOVE_UP, MOVE_DN: begin
                if (cnt_reg == TRAVEL_LAST) begin
                    cnt_next = '0;
                    // Saturate at the shaft ends so the floor stays in range.
                    if (state_reg == MOVE_UP)
                        arrive_floor = (floor_reg < TOP_FLOOR) ? floor_reg + FLOOR_W'(1) : floor_reg;
                    else
                        arrive_floor = (floor_reg != '0) ? floor_reg - FLOOR_W'(1) : floor_reg;
                    floor_next = arrive_floor;
                    if (pending_reg[arrive_floor]) begin
                        state_next               = DOOR;
                        clear_mask[arrive_floor] = 1'b1;
                    end else if ((state_reg == MOVE_UP && arrive_floor == TOP_FLOOR) ||
                                 (state_reg == MOVE_DN && arrive_floor == '0)) begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DOOR: begin
                // Calls for the open floor are absorbed while the door is open.
                clear_mask[floor_reg] = 1'b1;
`ifdef ELEV_DOOR_REOPEN_EN
                if (req[floor_reg]) begin
                    cnt_next = '0;
                end else
`endif
                if (cnt_reg == DOOR_LAST) begin
                    cnt_next = '0;
                    if (go_up) begin
                        state_next    = MOVE_UP;
                        last_dir_next = 1'b0;
                    end else if (go_down) begin
                        state_next    = MOVE_DN;
                        last_dir_next = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        dir       = DIR_IDLE;
        door_open = 1'b0;
        case (state_reg)
            MOVE_UP: dir       = DIR_UP;
            MOVE_DN: dir       = DIR_DN;
            DOOR:    door_open = 1'b1;
            default: dir       = DIR_IDLE;
        endcase
        busy = (state_reg != IDLE) || (pending_reg != '0);
    end

    assign floor   = floor_reg;
    assign state   = state_reg;
    assign pending = pending_reg;

endmodule

// File: doc/elevator_request_scheduler.md
# elevator_request_scheduler

Request-latching SCAN scheduler and car sequencer for the 5-floor (ground to fourth) elevator. It captures floor call buttons into a pending mask and chooses the travel direction by collective (SCAN) order. It also times the per-floor travel and door-open intervals, and drives the floor/direction/state outputs consumed by the car display and the top-level elevator model.

## Interface
- NUM_FLOORS, 5, number of served floors (floor 0 = ground); floor index width fixed at 3 bits
- TRAVEL_CYCLES, 4, clock cycles to move one floor (>=1)
- DOOR_CYCLES, 3, clock cycles door_open stays high per stop (>=1)
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low (rst=0 resets immediately, release synchronised externally)
- req  in  NUM_FLOORS  call buttons, bit i = floor i; level or pulse, sampled every edge
- floor  out  3  current car floor, 0..NUM_FLOORS-1
- dir  out  2  00 idle/stopped, 01 moving up, 10 moving down; 11 never driven
- state  out  3  0 IDLE, 1 MOVE_UP, 2 MOVE_DN, 3 DOOR
- door_open  out  1  high exactly while state==DOOR
- pending  out  NUM_FLOORS  latched unserved requests
- busy  out  1  high when state!=IDLE or pending!=0

## Operation
- pending <= (pending | req) & ~clear_mask each edge; clear_mask = bit of floor on DOOR entry, and bit of floor while in DOOR.
- Internal last_dir (up=0, down=1) remembers sweep direction; reset value up.
- IDLE: if pending[floor] -> DOOR. Else if pending above only -> MOVE_UP; below only -> MOVE_DN; both -> nearest side, equal distance -> MOVE_UP. Else stay.
- MOVE_UP/MOVE_DN: travel counter counts TRAVEL_CYCLES; on terminal count floor +/-1, counter clears. If pending[new floor] -> DOOR, else continue.
- DOOR: door counter counts DOOR_CYCLES; on terminal count evaluate SCAN: pending beyond floor in last_dir -> keep direction; else pending on the other side -> reverse; else IDLE.
- Boundaries: floor never exceeds NUM_FLOORS-1 or goes below 0; at top/bottom floor the beyond-set is empty, forcing reverse/idle. Request for the floor the car is passing mid-travel (counter non-zero) is served when that floor is reached only if car not yet past it; otherwise served on return sweep.
- rst=0 at any time (mid-move, mid-door): all outputs and counters to reset values at once; pending cleared, requests lost.

## Timing
- Reset values: floor=0, dir=00, state=IDLE(0), door_open=0, pending=0, busy=0.
- req high before edge k -> pending bit set after edge k -> state leaves IDLE after edge k+1.
- Move one floor = TRAVEL_CYCLES edges in MOVE state; floor and (if stopping) state=DOOR update on same edge.
- DOOR lasts exactly DOOR_CYCLES cycles, then next state on following edge per SCAN.
- dir is 01/10 only in MOVE_UP/MOVE_DN; 00 in IDLE and DOOR.
- Request at current floor while IDLE: DOOR entered after edge k+1, no movement.

## Configuration
- ELEV_DOOR_REOPEN_EN defined: req[floor] asserted during DOOR restarts door counter (door stays open DOOR_CYCLES more cycles after last such request).
- Not defined: req[floor] during DOOR is absorbed (cleared) with no extension; door closes on schedule.

## Structure
- Shared package elevator_pkg: state encodings (IDLE, MOVE_UP, MOVE_DN, DOOR), dir encodings (DIR_IDLE=00, DIR_UP=01, DIR_DN=10), default NUM_FLOORS.
- One sub-module elevator_dir_select: combinational SCAN decision from pending, floor, last_dir -> {go_up, go_down, stop_here}; used by IDLE and DOOR-exit paths.

## Test plan
- Reset, idle at 0, pulse req[3] one cycle -> dir=01 for 12 move cycles, floor 0->1->2->3, door_open 3 cycles, pending[3] cleared, returns to IDLE dir=00, busy=0.
- Idle at floor 0, req[0] -> state=DOOR two edges later, floor stays 0, dir stays 00, no MOVE state.
- From 0 serving req[4], assert req[2] while floor=1 -> stops at 2 (door 3 cycles) then continues up to 4.
- Idle at floor 2, req[0] and req[4] same cycle -> goes up first (tie), serves 4, reverses, serves 0, then IDLE.
- rst=0 while moving between floors 2 and 3 with pending[4] set -> same cycle floor=0, state=0, dir=00, pending=0, door_open=0.
- In DOOR at floor 1, req[1] at door cycle 2 -> with ELEV_DOOR_REOPEN_EN door open 3 further cycles; without, door closes on original schedule, pending[1] stays 0.
